// File: rtl/pattern_detect_ar.sv
// Masked pattern / pattern-bar detector with cep-qualified overflow history and P-register autoreset.
// Define PATDET_STATS_EN to build the sticky ov/un flags and the saturating match counter.
module pattern_detect_ar #(
    parameter int                         WIDTH            = 48,
    parameter int                         NUM_PAT          = 4,
    parameter logic [NUM_PAT*WIDTH-1:0]   PATTERNS         = '0,
    parameter logic [NUM_PAT*WIDTH-1:0]   MASKS            = '0,
    parameter string                      SEL_PATTERN      = "PATTERN",
    parameter string                      SEL_MASK         = "MASK",
    parameter int                         P_REG            = 1,
    parameter string                      AUTORESET_PATDET = "NO_RESET",
    parameter int                         CNT_WIDTH        = 16
) (
    input  logic                         clk,
    input  logic                         rstp,
    input  logic                         cep,
    input  logic [WIDTH-1:0]             p,
    input  logic [WIDTH-1:0]             c,
    input  logic [$clog2(NUM_PAT)-1:0]   pat_sel,
    input  logic                         clr_stat,
    output logic                         pd,
    output logic                         pbd,
    output logic                         ov_f,
    output logic                         un_f,
    output logic                         autoreset,
    output logic                         ov_sticky,
    output logic                         un_sticky,
    output logic [CNT_WIDTH-1:0]         match_cnt
);

    logic [WIDTH-1:0] pat_tbl_s  [NUM_PAT];
    logic [WIDTH-1:0] mask_tbl_s [NUM_PAT];
    logic [WIDTH-1:0] pat_s;
    logic [WIDTH-1:0] mask_s;
    logic             pd_d_s;
    logic             pbd_d_s;
    logic             ar_cond_s;
    logic             pd_past_r;
    logic             pbd_past_r;
    logic             autoreset_r;
    logic             unused_s;

    for (genvar gi = 0; gi < NUM_PAT; gi++) begin : g_tbl
        assign pat_tbl_s[gi]  = PATTERNS[gi*WIDTH +: WIDTH];
        assign mask_tbl_s[gi] = MASKS[gi*WIDTH +: WIDTH];
    end

    if (SEL_PATTERN == "C") begin : g_pat_c
        assign pat_s = c;
    end else begin : g_pat_tbl
        assign pat_s = pat_tbl_s[pat_sel];
    end

    // Rounding modes ignore the bits above the rounding point carried in c
    if (SEL_MASK == "C") begin : g_mask_c
        assign mask_s = c;
    end else if (SEL_MASK == "ROUNDING_MODE1") begin : g_mask_rm1
        assign mask_s = {~c[WIDTH-2:0], 1'b0};
    end else if (SEL_MASK == "ROUNDING_MODE2") begin : g_mask_rm2
        assign mask_s = {~c[WIDTH-3:0], 2'b00};
    end else begin : g_mask_tbl
        assign mask_s = mask_tbl_s[pat_sel];
    end

    assign pd_d_s  = &(~(p ^ pat_s) | mask_s);
    assign pbd_d_s = &(~(p ^ ~pat_s) | mask_s);

    if (P_REG == 1) begin : g_preg
        logic pd_r;
        logic pbd_r;
        // Detect flag register, advancing only on enabled edges
        always_ff @(posedge clk) begin
            if (rstp) begin
                pd_r  <= 1'b0;
                pbd_r <= 1'b0;
            end else if (cep) begin
                pd_r  <= pd_d_s;
                pbd_r <= pbd_d_s;
            end
        end
        assign pd  = pd_r;
        assign pbd = pbd_r;
    end else begin : g_comb
        assign pd  = pd_d_s;
        assign pbd = pbd_d_s;
    end

    if (AUTORESET_PATDET == "RESET_MATCH") begin : g_ar_match
        assign ar_cond_s = pd;
    end else if (AUTORESET_PATDET == "RESET_NOT_MATCH") begin : g_ar_nmatch
        assign ar_cond_s = pd_past_r & ~pd;
    end else begin : g_ar_none
        assign ar_cond_s = 1'b0;
    end

    // Flag history and autoreset request; history is wiped after a request so the
    // P-register reset it causes cannot look like an overflow/underflow
    always_ff @(posedge clk) begin
        if (rstp) begin
            pd_past_r   <= 1'b0;
            pbd_past_r  <= 1'b0;
            autoreset_r <= 1'b0;
        end else if (cep) begin
            autoreset_r <= ar_cond_s;
            if (autoreset_r) begin
                pd_past_r  <= 1'b0;
                pbd_past_r <= 1'b0;
            end else begin
                pd_past_r  <= pd;
                pbd_past_r <= pbd;
            end
        end else begin
            autoreset_r <= 1'b0;
        end
    end

    assign ov_f      = pd_past_r & ~pd & ~pbd;
    assign un_f      = pbd_past_r & ~pd & ~pbd;
    assign autoreset = autoreset_r;

`ifdef PATDET_STATS_EN
    logic                 ov_sticky_r;
    logic                 un_sticky_r;
    logic [CNT_WIDTH-1:0] match_cnt_r;

    // Sticky flags and saturating match counter; clr_stat beats set/increment
    always_ff @(posedge clk) begin
        if (rstp || clr_stat) begin
            ov_sticky_r <= 1'b0;
            un_sticky_r <= 1'b0;
            match_cnt_r <= '0;
        end else if (cep) begin
            if (ov_f) begin
                ov_sticky_r <= 1'b1;
            end
            if (un_f) begin
                un_sticky_r <= 1'b1;
            end
            if (pd && (match_cnt_r != {CNT_WIDTH{1'b1}})) begin
                match_cnt_r <= match_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign ov_sticky = ov_sticky_r;
    assign un_sticky = un_sticky_r;
    assign match_cnt = match_cnt_r;
`else
    assign ov_sticky = 1'b0;
    assign un_sticky = 1'b0;
    assign match_cnt = '0;
`endif

    // c only feeds the detector for C/rounding selections; clr_stat only with stats built
    assign unused_s = ^{c, clr_stat};

endmodule

// File: tb/tb_pattern_detect_ar.sv
// Directed bench for pattern_detect_ar: six configurations share one stimulus stream.
module tb_pattern_detect_ar;

    localparam logic [4*48-1:0] PAT_TBL  = {48'h0, 48'h0000_0000_0F00, 48'h0000_0000_00FF, 48'h0};
    localparam logic [4*48-1:0] MASK_TBL = {48'h0, 48'h0000_0000_000F, 48'h0, 48'h0};
`ifdef PATDET_STATS_EN
    localparam int ST = 1;
`else
    localparam int ST = 0;
`endif

    logic        clk;
    logic        rstp;
    logic        cep;
    logic [47:0] p;
    logic [47:0] c;
    logic [1:0]  pat_sel;
    logic        clr_stat;
    logic [5:0]  pd_v, pbd_v, ov_v, un_v, ar_v, ovs_v, uns_v;
    logic [1:0]  cnt_v [6];
    int          n_chk;
    int          n_pass;

    // 0: table/NO_RESET, 1: ROUNDING_MODE1, 2: ROUNDING_MODE2, 3: RESET_MATCH, 4: RESET_NOT_MATCH, 5: C source, P_REG=0
    pattern_detect_ar #(.WIDTH(48), .NUM_PAT(4), .PATTERNS(PAT_TBL), .MASKS(MASK_TBL), .SEL_PATTERN("PATTERN"),
        .SEL_MASK("MASK"), .P_REG(1), .AUTORESET_PATDET("NO_RESET"), .CNT_WIDTH(2)) u_main (
        .clk(clk), .rstp(rstp), .cep(cep), .p(p), .c(c), .pat_sel(pat_sel), .clr_stat(clr_stat),
        .pd(pd_v[0]), .pbd(pbd_v[0]), .ov_f(ov_v[0]), .un_f(un_v[0]), .autoreset(ar_v[0]),
        .ov_sticky(ovs_v[0]), .un_sticky(uns_v[0]), .match_cnt(cnt_v[0]));
    pattern_detect_ar #(.WIDTH(48), .NUM_PAT(4), .PATTERNS(PAT_TBL), .MASKS(MASK_TBL), .SEL_PATTERN("PATTERN"),
        .SEL_MASK("ROUNDING_MODE1"), .P_REG(1), .AUTORESET_PATDET("NO_RESET"), .CNT_WIDTH(2)) u_rm1 (
        .clk(clk), .rstp(rstp), .cep(cep), .p(p), .c(c), .pat_sel(pat_sel), .clr_stat(clr_stat),
        .pd(pd_v[1]), .pbd(pbd_v[1]), .ov_f(ov_v[1]), .un_f(un_v[1]), .autoreset(ar_v[1]),
        .ov_sticky(ovs_v[1]), .un_sticky(uns_v[1]), .match_cnt(cnt_v[1]));
    pattern_detect_ar #(.WIDTH(48), .NUM_PAT(4), .PATTERNS(PAT_TBL), .MASKS(MASK_TBL), .SEL_PATTERN("PATTERN"),
        .SEL_MASK("ROUNDING_MODE2"), .P_REG(1), .AUTORESET_PATDET("NO_RESET"), .CNT_WIDTH(2)) u_rm2 (
        .clk(clk), .rstp(rstp), .cep(cep), .p(p), .c(c), .pat_sel(pat_sel), .clr_stat(clr_stat),
        .pd(pd_v[2]), .pbd(pbd_v[2]), .ov_f(ov_v[2]), .un_f(un_v[2]), .autoreset(ar_v[2]),
        .ov_sticky(ovs_v[2]), .un_sticky(uns_v[2]), .match_cnt(cnt_v[2]));
    pattern_detect_ar #(.WIDTH(48), .NUM_PAT(4), .PATTERNS(PAT_TBL), .MASKS(MASK_TBL), .SEL_PATTERN("PATTERN"),
        .SEL_MASK("MASK"), .P_REG(1), .AUTORESET_PATDET("RESET_MATCH"), .CNT_WIDTH(2)) u_am (
        .clk(clk), .rstp(rstp), .cep(cep), .p(p), .c(c), .pat_sel(pat_sel), .clr_stat(clr_stat),
        .pd(pd_v[3]), .pbd(pbd_v[3]), .ov_f(ov_v[3]), .un_f(un_v[3]), .autoreset(ar_v[3]),
        .ov_sticky(ovs_v[3]), .un_sticky(uns_v[3]), .match_cnt(cnt_v[3]));
    pattern_detect_ar #(.WIDTH(48), .NUM_PAT(4), .PATTERNS(PAT_TBL), .MASKS(MASK_TBL), .SEL_PATTERN("PATTERN"),
        .SEL_MASK("MASK"), .P_REG(1), .AUTORESET_PATDET("RESET_NOT_MATCH"), .CNT_WIDTH(2)) u_anm (
        .clk(clk), .rstp(rstp), .cep(cep), .p(p), .c(c), .pat_sel(pat_sel), .clr_stat(clr_stat),
        .pd(pd_v[4]), .pbd(pbd_v[4]), .ov_f(ov_v[4]), .un_f(un_v[4]), .autoreset(ar_v[4]),
        .ov_sticky(ovs_v[4]), .un_sticky(uns_v[4]), .match_cnt(cnt_v[4]));
    pattern_detect_ar #(.WIDTH(48), .NUM_PAT(4), .PATTERNS(PAT_TBL), .MASKS(MASK_TBL), .SEL_PATTERN("C"),
        .SEL_MASK("C"), .P_REG(0), .AUTORESET_PATDET("NO_RESET"), .CNT_WIDTH(2)) u_comb (
        .clk(clk), .rstp(rstp), .cep(cep), .p(p), .c(c), .pat_sel(pat_sel), .clr_stat(clr_stat),
        .pd(pd_v[5]), .pbd(pbd_v[5]), .ov_f(ov_v[5]), .un_f(un_v[5]), .autoreset(ar_v[5]),
        .ov_sticky(ovs_v[5]), .un_sticky(uns_v[5]), .match_cnt(cnt_v[5]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstp = 1'b1; cep = 1'b0; clr_stat = 1'b0; p = '0; c = '0; pat_sel = 2'd1;
        tick();
        rstp = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;

        // reset wins over cep and clr_stat with a matching p present
        rstp = 1'b1; cep = 1'b1; clr_stat = 1'b1; p = 48'hFF; c = '0; pat_sel = 2'd1;
        tick();
        check_eq("rst_pd", int'(pd_v[0]), 0);
        check_eq("rst_ovf", int'(ov_v[0]), 0);
        check_eq("rst_ar", int'(ar_v[3]), 0);
        check_eq("rst_cnt", int'(cnt_v[0]), 0);
        rstp = 1'b0; clr_stat = 1'b0;

        // basic detect, pattern-bar, underflow
        tick();
        check_eq("basic_pd", int'(pd_v[0]), 1);
        check_eq("basic_pbd0", int'(pbd_v[0]), 0);
        p = 48'hFFFF_FFFF_FF00;
        tick();
        check_eq("bar_pd", int'(pd_v[0]), 0);
        check_eq("bar_pbd", int'(pbd_v[0]), 1);
        check_eq("bar_no_ovf", int'(ov_v[0]), 0);
        p = '0;
        tick();
        check_eq("unf_fire", int'(un_v[0]), 1);
        check_eq("unf_no_ovf", int'(ov_v[0]), 0);
        tick();
        check_eq("unf_clear", int'(un_v[0]), 0);
        check_eq("uns_set", int'(uns_v[0]), ST);
        check_eq("ovs_clean", int'(ovs_v[0]), 0);

        // table entry with masked low nibble
        do_reset();
        pat_sel = 2'd2; cep = 1'b1; p = 48'h0000_0000_0F0A;
        tick();
        check_eq("tblmask_hit", int'(pd_v[0]), 1);
        p = 48'h0000_0000_0E0A;
        tick();
        check_eq("tblmask_miss", int'(pd_v[0]), 0);

        // rounding masks: c=3 -> MODE1 compares [2:0], MODE2 compares [3:0]
        do_reset();
        cep = 1'b1; c = 48'h3; p = 48'h0000_0000_00FE;
        tick();
        check_eq("rm1_b0", int'(pd_v[1]), 0);
        check_eq("rm2_b0", int'(pd_v[2]), 0);
        p = 48'h0000_0000_00F7;
        tick();
        check_eq("rm1_b3", int'(pd_v[1]), 1);
        check_eq("rm2_b3", int'(pd_v[2]), 0);
        p = 48'h8000_0000_00FF;
        tick();
        check_eq("rm1_b47", int'(pd_v[1]), 1);
        check_eq("rm2_b47", int'(pd_v[2]), 1);
        // c=2 -> MODE1 compares bits 0,2; MODE2 compares bits 0,1,3
        c = 48'h2; p = 48'h0000_0000_00FB;
        tick();
        check_eq("rm1_b2", int'(pd_v[1]), 0);
        check_eq("rm2_b2", int'(pd_v[2]), 1);

        // overflow, sticky latency and stall behaviour
        do_reset();
        cep = 1'b1; p = 48'hFF;
        tick();
        p = '0;
        tick();
        check_eq("ovf_fire", int'(ov_v[0]), 1);
        check_eq("ovs_late", int'(ovs_v[0]), 0);
        tick();
        check_eq("ovf_clear", int'(ov_v[0]), 0);
        check_eq("ovs_set", int'(ovs_v[0]), ST);
        p = 48'hFF;
        tick();
        cep = 1'b0; p = '0;
        tick();
        check_eq("stall_pd", int'(pd_v[0]), 1);
        check_eq("stall_no_ovf", int'(ov_v[0]), 0);
        tick();
        cep = 1'b1;
        tick();
        check_eq("ovf_on_cep", int'(ov_v[0]), 1);
        cep = 1'b0;
        tick();
        check_eq("ovf_held", int'(ov_v[0]), 1);
        cep = 1'b1;
        tick();
        check_eq("ovf_aged", int'(ov_v[0]), 0);

        // autoreset: single matching sample, then a match held until the P reset lands
        do_reset();
        cep = 1'b1; p = 48'hFF;
        tick();
        check_eq("am_idle", int'(ar_v[3]), 0);
        p = '0;
        tick();
        check_eq("am_pulse", int'(ar_v[3]), 1);
        check_eq("anm_wait", int'(ar_v[4]), 0);
        tick();
        check_eq("am_one_cyc", int'(ar_v[3]), 0);
        check_eq("anm_pulse", int'(ar_v[4]), 1);
        tick();
        check_eq("anm_one_cyc", int'(ar_v[4]), 0);
        p = 48'hFF;
        tick();
        tick();
        check_eq("am_held", int'(ar_v[3]), 1);
        check_eq("am_held_ovf", int'(ov_v[3]), 0);
        check_eq("anm_held", int'(ar_v[4]), 0);
        p = '0;
        tick();
        check_eq("am_no_ovf", int'(ov_v[3]), 0);
        check_eq("nr_ovf", int'(ov_v[0]), 1);
        check_eq("anm_hold1", int'(ar_v[4]), 0);
        tick();
        check_eq("am_drop", int'(ar_v[3]), 0);
        check_eq("am_no_ovf2", int'(ov_v[3]), 0);
        check_eq("anm_fall", int'(ar_v[4]), 1);
        cep = 1'b0;
        tick();
        check_eq("anm_stall", int'(ar_v[4]), 0);

        // saturating counter and clr_stat priority
        do_reset();
        cep = 1'b1; p = 48'hFF;
        tick(); tick(); tick();
        check_eq("cnt_two", int'(cnt_v[0]), 2 * ST);
        tick(); tick();
        check_eq("cnt_sat", int'(cnt_v[0]), 3 * ST);
        clr_stat = 1'b1;
        tick();
        check_eq("cnt_clr", int'(cnt_v[0]), 0);
        clr_stat = 1'b0;

        // reset in mid-operation
        do_reset();
        cep = 1'b1; p = 48'hFF;
        tick();
        p = '0;
        tick(); tick();
        p = 48'hFF;
        tick(); tick();
        check_eq("mid_pd", int'(pd_v[0]), 1);
        check_eq("mid_ovs", int'(ovs_v[0]), ST);
        check_eq("mid_cnt", int'(cnt_v[0]), 2 * ST);
        rstp = 1'b1;
        tick();
        check_eq("mid_rst_pd", int'(pd_v[0]), 0);
        check_eq("mid_rst_ovs", int'(ovs_v[0]), 0);
        check_eq("mid_rst_cnt", int'(cnt_v[0]), 0);
        check_eq("mid_rst_ovf", int'(ov_v[0]), 0);
        rstp = 1'b0; p = '0;
        tick();
        check_eq("post_rst_ovf", int'(ov_v[0]), 0);

        // C-sourced pattern and mask with zero latency
        c = 48'hF; p = 48'h5;
        #1;
        check_eq("comb_hit", int'(pd_v[5]), 1);
        p = 48'h15;
        #1;
        check_eq("comb_miss", int'(pd_v[5]), 0);
        p = 48'hFFFF_FFFF_FFF3;
        #1;
        check_eq("comb_pbd", int'(pbd_v[5]), 1);
        check_eq("comb_pd0", int'(pd_v[5]), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
